scalar_alu_result_buffer: RTL

//  Downstream stage of the scalar ALU: registers ALU result + flags + dest tag into a
//  2-entry skid buffer and presents it to scalar writeback with valid/ready handshake.

---
 rtl/scalar_alu_result_buffer_pkg.sv | 25 ++
 rtl/scalar_alu_result_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/scalar_alu_result_buffer_pkg.sv
// Shared scalar datapath types for the ALU result buffer.
// WORD_W / REG_W are fixed here so every stage agrees on alu_result_t layout.
package scalar_alu_result_buffer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        word_t    data;
        logic     zf;
        logic     nf;
        logic     of;
        regbits_t rd;
        logic     wen;
    } alu_result_t;

    // Register 0 is hard-wired zero, so it is never a forwarding source.
    function automatic logic is_forwardable(input logic valid, input logic wen, input regbits_t rd);
        return valid & wen & (rd != '0);
    endfunction

endpackage

// File: rtl/scalar_alu_result_buffer.sv
// Two-entry skid buffer between the scalar ALU and writeback.
// Head entry drives writeback and forwarding; skid entry absorbs one
// result when writeback stalls so in_ready never depends on out_ready
// combinationally.
// Optional feature macro: SCALAR_OF_TRAP_EN (overflow suppresses the
// register write and raises a sticky of_trap output).
module scalar_alu_result_buffer
    import scalar_alu_result_buffer_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  word_t       in_out,
    input  logic        in_zf,
    input  logic        in_nf,
    input  logic        in_of,
    input  regbits_t    in_rd,
    input  logic        in_wen,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output word_t       out_data,
    output logic        out_zf,
    output logic        out_nf,
    output logic        out_of,
    output regbits_t    out_rd,
    output logic        out_wen,
    output logic        fwd_valid,
    output regbits_t    fwd_rd,
    output word_t       fwd_data
`ifdef SCALAR_OF_TRAP_EN
   ,output logic        of_trap
`endif
);

    alu_result_t head, skid, head_nxt, skid_nxt, in_entry;
    logic        head_valid, skid_valid, head_valid_nxt, skid_valid_nxt;
    logic        push, pop;
`ifdef SCALAR_OF_TRAP_EN
    logic        trap, trap_nxt;
`endif

    // Package the incoming ALU result; overflow optionally kills the write.
    always_comb begin
        in_entry.data = in_out;
        in_entry.zf   = in_zf;
        in_entry.nf   = in_nf;
        in_entry.of   = in_of;
        in_entry.rd   = in_rd;
`ifdef SCALAR_OF_TRAP_EN
        in_entry.wen  = in_wen & ~in_of;
`else
        in_entry.wen  = in_wen;
`endif
    end

    // Handshake and next-state selection for head/skid entries.
    always_comb begin
        in_ready       = ~skid_valid;
        push           = in_valid & ~skid_valid;
        pop            = head_valid & out_ready;
        head_nxt       = head;
        skid_nxt       = skid;
        head_valid_nxt = head_valid;
        skid_valid_nxt = skid_valid;
`ifdef SCALAR_OF_TRAP_EN
        trap_nxt       = trap | (push & in_of);
`endif
        if (flush) begin
            head_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
`ifdef SCALAR_OF_TRAP_EN
            trap_nxt       = 1'b0;
`endif
        end else if (!head_valid) begin
            // Skid can only hold data while head is full, so it is empty here.
            if (push) begin
                head_nxt       = in_entry;
                head_valid_nxt = 1'b1;
            end
        end else if (pop) begin
            // A push alongside a pop implies the skid was empty.
            if (skid_valid) begin
                head_nxt = skid;
            end else if (push) begin
                head_nxt = in_entry;
            end else begin
                head_valid_nxt = 1'b0;
            end
            skid_valid_nxt = 1'b0;
        end else if (push) begin
            skid_nxt       = in_entry;
            skid_valid_nxt = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head       <= '0;
            skid       <= '0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
`ifdef SCALAR_OF_TRAP_EN
            trap       <= 1'b0;
`endif
        end else begin
            head       <= head_nxt;
            skid       <= skid_nxt;
            head_valid <= head_valid_nxt;
            skid_valid <= skid_valid_nxt;
`ifdef SCALAR_OF_TRAP_EN
            trap       <= trap_nxt;
`endif
        end
    end

    // Outputs come from the head entry only.
    always_comb begin
        out_valid = head_valid;
        out_data  = head.data;
        out_zf    = head.zf;
        out_nf    = head.nf;
        out_of    = head.of;
        out_rd    = head.rd;
        out_wen   = head.wen;
        fwd_valid = is_forwardable(head_valid, head.wen, head.rd);
        fwd_rd    = head.rd;
        fwd_data  = head.data;
`ifdef SCALAR_OF_TRAP_EN
        of_trap   = trap;
`endif
    end

endmodule
